serializer_arbiter: RTL and testbench
=====================================

# serializer_arbiter

Round-robin controller that shares one word-to-bit serializer (`LENGTH`-bit parallel load, LSB-first shift-out) between `N` parallel-word requesters. It latches one requester's word, issues it to the serializer with a valid/ready load handshake, and counts accepted output bits until the frame completes. It then advances priority and arbitrates again. It sits between the upstream producers (FIR output channels) and the single serializer instance, and tags the active bit stream with its channel number.

## Interface
- `LENGTH`, 32, bits per word; must match the serializer's `LENGTH`.
- `N`, 4, number of requesters, 2..16.
- `CH_BITS`, `$clog2(N)`, derived; width of the channel index.

- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: clock enable; when low, all registers hold.
- `iv_req_data` in `N*LENGTH`: request words; channel k occupies bits `[k*LENGTH +: LENGTH]`.
- `iv_req_valid` in `N`: per-channel request valid; held until acked.
- `ov_req_ack` out `N`: one-cycle, one-hot pulse; the word has been latched.
- `ov_ser_din` out `LENGTH`: word to the serializer (`iv_din`).
- `o_ser_din_valid` out 1: load request to the serializer (`i_din_valid`).
- `i_ser_ready` in 1: serializer load-accepted pulse (its `o_ready`).
- `i_ser_dout_valid` in 1: serializer bit valid (its `o_dout_valid`).
- `i_sink_ready` in 1: downstream bit ready; also drives the serializer's `i_ready`.
- `ov_grant` out `CH_BITS`: channel currently owning the serializer.
- `o_grant_valid` out 1: `ov_grant` is meaningful (ISSUE or STREAM).
- `o_frame_end` out 1: one-cycle pulse when the `LENGTH`-th bit is accepted.

## Operation
- **State register:** one-hot or binary; states ARB, ISSUE, STREAM, DONE.
- **Internal registers:**
  - word latch `LENGTH` bits
  - priority pointer `ptr`, `CH_BITS` bits
  - grant register
  - beat counter `$clog2(LENGTH+1)` bits
- **ARB:**
  - Search `iv_req_valid` starting at `ptr`, wrapping at N-1 to 0. The first set bit wins.
  - If no request is set, stay in ARB.
  - On a win, go to ISSUE. On the same edge: latch the winner's word, register the grant, and clear the beat counter.
- **ISSUE:**
  - `o_ser_din_valid`=1 and `ov_ser_din`=latched word, held stable.
  - `ov_req_ack[grant]`=1 in the first ISSUE cycle only.
  - When `i_ser_ready` is 1, go to STREAM. `o_ser_din_valid` is 0 from the next cycle.
- **STREAM:**
  - Each cycle with `i_ser_dout_valid && i_sink_ready` increments the beat counter.
  - On the beat where the counter goes from `LENGTH-1` to `LENGTH`: pulse `o_frame_end` (registered, high in the next cycle) and go to DONE.
- **DONE:** one cycle. Set `ptr` = (grant+1) mod N, drop `o_grant_valid`, return to ARB.
- **Fairness:** the channel just served has lowest priority in the next ARB. A continuously requesting channel waits at most N-1 frames.
- **Request changes:**
  - `iv_req_data` or `iv_req_valid` changing after the ack has no effect on the frame in flight.
  - Requests are not sampled outside ARB.
- **Unexpected inputs:**
  - `i_ser_ready` is ignored outside ISSUE.
  - `i_ser_dout_valid` is ignored outside STREAM.
  - An unreachable state goes to ARB.

## Timing
- **Reset values** (whenever `i_rst`=1 on an edge, regardless of `i_en` and including mid-frame): state ARB, `ptr`=0, beat counter 0, word latch 0, and all outputs 0 (`ov_req_ack`, `ov_ser_din`, `o_ser_din_valid`, `ov_grant`, `o_grant_valid`, `o_frame_end`).
- **Latency:** request valid sampled in ARB at edge t.
  - `ov_req_ack`, `o_ser_din_valid` and `o_grant_valid` are high in cycle t+1.
- **Serializer load:** the serializer's `o_ready` arrives about 2 cycles after `o_ser_din_valid` rises.
  - `o_ser_din_valid` stays high until `i_ser_ready` is sampled.
  - No timeout.
- **Frame length:** exactly `LENGTH` accepted beats; stalls of `i_sink_ready` extend it without limit.
- **Minimum spacing:** `LENGTH`+5 cycles between consecutive acks with no backpressure.
- **`i_en`=0:** state, counters and all outputs freeze. Pulses (`ov_req_ack`, `o_frame_end`) stay at their current value and are not re-issued or lost. Beats are not counted.
- **Beat on the ISSUE→STREAM edge:** a `i_ser_dout_valid` beat in the same cycle as the ISSUE→STREAM transition is not counted. The serializer cannot emit a bit before STREAM.

## Test plan
- **Single request:** reset, then channel 2 requests 32'hA5A50F0F.
  - ack[2] is a single pulse.
  - `ov_ser_din`=32'hA5A50F0F until `i_ser_ready`.
  - The sink receives bits 1,1,1,1,0,0,0,0,… (LSB first).
  - `o_frame_end` after beat 32; `ov_grant`=2 throughout.
- **Round robin:** all 4 channels valid continuously.
  - Grant order 0,1,2,3,0,1.
  - Each ack is exactly one cycle, one-hot.
  - Ack spacing is 37 cycles with `i_sink_ready`=1.
- **Pointer wrap:** serve channel 3, then raise channels 1 and 3 together → channel 1 is granted first (ptr=0 after wrap), then channel 3.
- **Backpressure:** toggle `i_sink_ready` 1,0,0,1 repeating during STREAM → exactly 32 counted beats; `o_frame_end` only after the 32nd accepted beat.
- **Reset mid-frame:** assert `i_rst` at beat 10.
  - Next cycle: all outputs 0, state ARB, `ptr`=0.
  - The pending channel is re-granted only after it re-requests.
- **Enable freeze:** drop `i_en` for 5 cycles in ISSUE and in STREAM.
  - Outputs hold.
  - Beat count and final bit sequence are identical to the `i_en`=1 run, shifted by 5 cycles.

Source files
------------

// File: rtl/serializer_arbiter.sv
// Round-robin owner of one shared word-to-bit serializer: grant/ack one cycle after a request is seen in ARB,
// load held until the serializer accepts it, frame ends after LENGTH sink-accepted beats (stalls extend it).
module serializer_arbiter #(
  parameter int LENGTH  = 32,
  parameter int N       = 4,
  parameter int CH_BITS = $clog2(N)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [N*LENGTH-1:0]   iv_req_data,
  input  logic [N-1:0]          iv_req_valid,
  output logic [N-1:0]          ov_req_ack,
  output logic [LENGTH-1:0]     ov_ser_din,
  output logic                  o_ser_din_valid,
  input  logic                  i_ser_ready,
  input  logic                  i_ser_dout_valid,
  input  logic                  i_sink_ready,
  output logic [CH_BITS-1:0]    ov_grant,
  output logic                  o_grant_valid,
  output logic                  o_frame_end
);

  localparam int BEAT_BITS = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [LENGTH-1:0]    r_word;
  logic [CH_BITS-1:0]   r_ptr;
  logic [CH_BITS-1:0]   r_grant;
  logic [BEAT_BITS-1:0] r_beat;
  logic                 r_first;
  logic                 w_win;
  logic [CH_BITS-1:0]   w_win_ch;
  logic                 w_beat;
  logic                 w_last_beat;

  // Search starts at the pointer and wraps, so the last served channel is checked last.
  always_comb begin
    int idx;
    idx      = 0;
    w_win    = 1'b0;
    w_win_ch = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!w_win && iv_req_valid[idx[CH_BITS-1:0]]) begin
        w_win    = 1'b1;
        w_win_ch = idx[CH_BITS-1:0];
      end
    end
  end

  assign w_beat      = (r_state == STREAM) && i_ser_dout_valid && i_sink_ready;
  assign w_last_beat = w_beat && (r_beat == BEAT_BITS'(LENGTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (w_win)       w_next = ISSUE;
      ISSUE:   if (i_ser_ready) w_next = STREAM;
      STREAM:  if (w_last_beat) w_next = DONE;
      DONE:    w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word  <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_beat  <= '0;
      r_first <= 1'b0;
    end else if (i_en) begin
      r_first <= (r_state == ARB) && w_win;
      if ((r_state == ARB) && w_win) begin
        r_word  <= iv_req_data[int'(w_win_ch)*LENGTH +: LENGTH];
        r_grant <= w_win_ch;
        r_beat  <= '0;
      end
      if (w_beat) begin
        r_beat <= r_beat + 1'b1;
      end
      if (r_state == DONE) begin
        r_ptr <= (r_grant == CH_BITS'(N - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  // Outputs decode from registered state, so a frozen enable freezes every output with it.
  always_comb begin
    ov_req_ack = '0;
    if (r_first) ov_req_ack[r_grant] = 1'b1;
    o_ser_din_valid = (r_state == ISSUE);
    o_grant_valid   = (r_state == ISSUE) || (r_state == STREAM);
    o_frame_end     = (r_state == DONE);
  end

  assign ov_ser_din = r_word;
  assign ov_grant   = r_grant;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a small behavioural serializer and bit sink.
module tb_serializer_arbiter;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_en = 1'b0;
  logic [127:0] iv_req_data = '0;
  logic [3:0]   iv_req_valid = '0;
  logic [3:0]   ov_req_ack;
  logic [31:0]  ov_ser_din;
  logic         o_ser_din_valid;
  logic         i_ser_ready = 1'b0;
  logic         i_ser_dout_valid = 1'b0;
  logic         i_sink_ready = 1'b1;
  logic [1:0]   ov_grant;
  logic         o_grant_valid;
  logic         o_frame_end;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int last_beat_cyc = 0;
  logic [31:0] rx_word = '0;

  int          m_cnt = 0;
  int          m_left = 0;
  logic [31:0] m_sh = '0;

  serializer_arbiter #(.LENGTH(32), .N(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .iv_req_data(iv_req_data), .iv_req_valid(iv_req_valid), .ov_req_ack(ov_req_ack),
    .ov_ser_din(ov_ser_din), .o_ser_din_valid(o_ser_din_valid), .i_ser_ready(i_ser_ready),
    .i_ser_dout_valid(i_ser_dout_valid), .i_sink_ready(i_sink_ready),
    .ov_grant(ov_grant), .o_grant_valid(o_grant_valid), .o_frame_end(o_frame_end)
  );

  always #5 i_clk = ~i_clk;

  // One clock: serializer answers a load 2 cycles after it appears, then shifts LSB first.
  task automatic step();
    logic p_dv, p_rdy, p_en, p_out, p_sink, p_rst;
    logic [31:0] p_din;
    p_dv = o_ser_din_valid; p_rdy = i_ser_ready; p_en = i_en;
    p_out = i_ser_dout_valid; p_sink = i_sink_ready; p_rst = i_rst; p_din = ov_ser_din;
    @(posedge i_clk);
    #1;
    cyc++;
    if (p_rst) begin
      m_cnt = 0; m_left = 0; m_sh = '0; i_ser_ready = 1'b0;
    end else if (p_en) begin
      if (p_out && p_sink) begin
        if (beats < 32) rx_word[beats] = m_sh[0];
        beats++;
        last_beat_cyc = cyc;
        m_sh = m_sh >> 1;
        m_left--;
      end
      if (p_rdy) begin
        m_sh = p_din; m_left = 32; m_cnt = 0; i_ser_ready = 1'b0;
      end else if (p_dv && m_left == 0) begin
        m_cnt++;
        if (m_cnt == 2) i_ser_ready = 1'b1;
      end
    end
    i_ser_dout_valid = (m_left != 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; step(); step(); i_rst = 1'b0;
    beats = 0; rx_word = '0;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] ack, output bit ok);
    ok = 1'b0; ack = '0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ov_req_ack != 4'b0) begin ack = ov_req_ack; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_frame_end) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    i_en = 1'b0; i_rst = 1'b1; step(); step();
    checks++;
    if ({ov_req_ack, ov_ser_din, o_ser_din_valid} !== 37'b0) begin
      errors++; $display("FAIL reset_data: got ack=%b din=%h dv=%b, want 0", ov_req_ack, ov_ser_din, o_ser_din_valid);
    end
    checks++;
    if ({ov_grant, o_grant_valid, o_frame_end} !== 4'b0) begin
      errors++; $display("FAIL reset_grant: got grant=%0d gv=%b fe=%b, want 0", ov_grant, o_grant_valid, o_frame_end);
    end
    i_rst = 1'b0; i_en = 1'b1; step(); step();
    checks++;
    if ({ov_req_ack, o_ser_din_valid, o_grant_valid, o_frame_end} !== 7'b0) begin
      errors++; $display("FAIL reset_idle: got ack=%b dv=%b gv=%b fe=%b, want 0", ov_req_ack, o_ser_din_valid, o_grant_valid, o_frame_end);
    end
  endtask

  task automatic test_single();
    logic [3:0] ack; bit ok; int extra, din_bad, grant_bad;
    do_reset();
    iv_req_data = {32'h1111_2222, 32'hA5A5_0F0F, 32'h3333_4444, 32'h5555_6666};
    iv_req_valid = 4'b0100;
    wait_ack(10, ack, ok);
    checks++;
    if (!ok || ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b ok=%0d, want 0100", ack, ok); end
    checks++;
    if ({o_ser_din_valid, o_grant_valid, ov_grant} !== 4'b1110) begin
      errors++; $display("FAIL single_issue: got dv=%b gv=%b grant=%0d, want 1 1 2", o_ser_din_valid, o_grant_valid, ov_grant);
    end
    checks++;
    if (ov_ser_din !== 32'hA5A5_0F0F) begin errors++; $display("FAIL single_din: got %h, want a5a50f0f", ov_ser_din); end
    iv_req_valid = '0; iv_req_data[64 +: 32] = 32'h0;
    extra = 0; din_bad = 0; grant_bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ov_req_ack !== 4'b0) extra++;
      if (o_ser_din_valid && ov_ser_din !== 32'hA5A5_0F0F) din_bad++;
      if (o_grant_valid && ov_grant !== 2'd2) grant_bad++;
      if (o_frame_end) break;
    end
    checks++;
    if (extra != 0 || din_bad != 0 || grant_bad != 0) begin
      errors++; $display("FAIL single_hold: got extra_ack=%0d din_bad=%0d grant_bad=%0d, want 0 0 0", extra, din_bad, grant_bad);
    end
    checks++;
    if (o_frame_end !== 1'b1 || beats != 32 || cyc != last_beat_cyc) begin
      errors++; $display("FAIL single_frame_end: got fe=%b beats=%0d cyc=%0d last_beat=%0d, want fe after beat 32", o_frame_end, beats, cyc, last_beat_cyc);
    end
    checks++;
    if (rx_word[7:0] !== 8'h0F || rx_word !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL single_bits: got %h, want a5a50f0f", rx_word);
    end
    checks++;
    if (o_grant_valid !== 1'b0) begin errors++; $display("FAIL single_done_gv: got %b, want 0", o_grant_valid); end
    step();
    checks++;
    if (o_frame_end !== 1'b0) begin errors++; $display("FAIL single_fe_pulse: got %b, want 0", o_frame_end); end
  endtask

  task automatic test_round_robin();
    logic [3:0] ack; bit ok; int prev, exp_ch;
    do_reset();
    iv_req_data = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    iv_req_valid = 4'hF;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      exp_ch = n % 4;
      wait_ack(80, ack, ok);
      checks++;
      if (!ok || ack !== (4'b1 << exp_ch) || ov_ser_din !== iv_req_data[exp_ch*32 +: 32]) begin
        errors++; $display("FAIL rr_grant%0d: got ack=%b din=%h, want ch %0d", n, ack, ov_ser_din, exp_ch);
      end
      if (n > 0) begin
        checks++;
        if (cyc - prev != 37) begin errors++; $display("FAIL rr_spacing%0d: got %0d, want 37", n, cyc - prev); end
      end
      prev = cyc;
      step();
      checks++;
      if (ov_req_ack !== 4'b0) begin errors++; $display("FAIL rr_pulse%0d: got %b, want 0000", n, ov_req_ack); end
    end
    iv_req_valid = '0;
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] ack; bit ok;
    do_reset();
    iv_req_valid = 4'b1000;
    wait_ack(10, ack, ok);
    iv_req_valid = '0;
    wait_fe(80, ok);
    checks++;
    if (!ok || ack !== 4'b1000) begin errors++; $display("FAIL wrap_first: got ack=%b fe_seen=%0d, want 1000 1", ack, ok); end
    iv_req_valid = 4'b1010;
    wait_ack(10, ack, ok);
    checks++;
    if (!ok || ack !== 4'b0010) begin errors++; $display("FAIL wrap_ch1: got %b, want 0010", ack); end
    iv_req_valid = 4'b1000;
    wait_ack(80, ack, ok);
    checks++;
    if (!ok || ack !== 4'b1000) begin errors++; $display("FAIL wrap_ch3: got %b, want 1000", ack); end
    iv_req_valid = '0;
    wait_fe(80, ok);
  endtask

  task automatic test_backpressure();
    logic [3:0] ack; logic [3:0] pat; bit seen;
    bit ok;
    pat = 4'b1001;
    do_reset();
    iv_req_data[31:0] = 32'h3C5A_9617;
    iv_req_valid = 4'b0001;
    wait_ack(10, ack, ok);
    iv_req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      i_sink_ready = pat[k % 4];
      step();
      if (o_frame_end) begin seen = 1'b1; break; end
    end
    i_sink_ready = 1'b1;
    checks++;
    if (!seen || beats != 32 || cyc != last_beat_cyc) begin
      errors++; $display("FAIL bp_frame_end: got seen=%0d beats=%0d cyc=%0d last_beat=%0d, want end right after beat 32", seen, beats, cyc, last_beat_cyc);
    end
    checks++;
    if (rx_word !== 32'h3C5A_9617) begin errors++; $display("FAIL bp_bits: got %h, want 3c5a9617", rx_word); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ack; bit ok; int stray;
    do_reset();
    iv_req_data[63:32] = 32'h1234_5678;
    iv_req_valid = 4'b0010;
    wait_ack(10, ack, ok);
    iv_req_valid = '0;
    wait_fe(80, ok);
    iv_req_valid = 4'b0010;
    wait_ack(10, ack, ok);
    iv_req_valid = '0;
    beats = 0;
    for (int i = 0; i < 60 && beats < 10; i++) step();
    checks++;
    if (beats != 10 || o_grant_valid !== 1'b1) begin errors++; $display("FAIL mid_reach10: got beats=%0d gv=%b, want 10 1", beats, o_grant_valid); end
    i_rst = 1'b1; step(); i_rst = 1'b0;
    checks++;
    if ({ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end} !== 41'b0) begin
      errors++; $display("FAIL mid_reset_outs: got ack=%b din=%h dv=%b grant=%0d gv=%b fe=%b, want 0", ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end);
    end
    stray = 0;
    for (int i = 0; i < 5; i++) begin step(); if (ov_req_ack !== 4'b0 || o_grant_valid) stray++; end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL mid_no_regrant: got %0d active cycles, want 0", stray); end
    iv_req_valid = 4'b1010;
    wait_ack(10, ack, ok);
    checks++;
    if (!ok || ack !== 4'b0010) begin errors++; $display("FAIL mid_ptr0: got %b, want 0010", ack); end
    iv_req_valid = '0;
    wait_fe(80, ok);
  endtask

  task automatic test_enable_freeze();
    logic [3:0] ack; bit ok; int a_cyc, bad, b0;
    logic [40:0] snap;
    do_reset();
    iv_req_data[95:64] = 32'h5EC0_7A31;
    iv_req_valid = 4'b0100;
    wait_ack(10, ack, ok);
    a_cyc = cyc;
    iv_req_valid = '0;
    bad = 0;
    i_en = 1'b0;
    snap = {ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end};
    for (int i = 0; i < 5; i++) begin
      step();
      if ({ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end} !== snap) bad++;
    end
    checks++;
    if (bad != 0 || ov_req_ack !== 4'b0100) begin errors++; $display("FAIL en_issue_hold: got bad=%0d ack=%b, want 0 0100", bad, ov_req_ack); end
    i_en = 1'b1;
    for (int i = 0; i < 60 && beats < 16; i++) step();
    i_en = 1'b0;
    b0 = beats; bad = 0;
    snap = {ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end};
    for (int i = 0; i < 5; i++) begin
      step();
      if ({ov_req_ack, ov_ser_din, o_ser_din_valid, ov_grant, o_grant_valid, o_frame_end} !== snap) bad++;
    end
    checks++;
    if (bad != 0 || b0 != 16 || beats != 16) begin errors++; $display("FAIL en_stream_hold: got bad=%0d beats=%0d/%0d, want 0 16/16", bad, b0, beats); end
    i_en = 1'b1;
    wait_fe(80, ok);
    checks++;
    if (!ok || beats != 32 || cyc - a_cyc != 45) begin
      errors++; $display("FAIL en_timing: got fe=%0d beats=%0d span=%0d, want 1 32 45", ok, beats, cyc - a_cyc);
    end
    checks++;
    if (rx_word !== 32'h5EC0_7A31) begin errors++; $display("FAIL en_bits: got %h, want 5ec07a31", rx_word); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_backpressure();
    test_reset_mid();
    test_enable_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
